// File: rtl/seg_seconds_pkg.sv
// Shared types and constants for the seven-segment seconds controller:
// command encodings, controller states and the digit-to-segment table.
package seg_seconds_pkg;

    typedef enum logic [1:0] {
        OP_START = 2'b00,
        OP_STOP  = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        STOPPED = 2'b00,
        RUN     = 2'b01,
        BUSY    = 2'b10
    } state_e;

    localparam int          NUM_DIGITS = 10;
    localparam logic [3:0]  LAST_DIGIT = 4'd9;

    // Segment order is gfedcba, active-high.
    localparam logic [6:0] SEG_LUT [NUM_DIGITS] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    function automatic logic [3:0] next_digit(input logic [3:0] d);
        return (d >= LAST_DIGIT) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic digit_in_range(input logic [3:0] d);
        return d <= LAST_DIGIT;
    endfunction

endpackage

// File: rtl/seg_seconds_ctrl_if.sv
// Host command channel: valid/ready handshake carrying an opcode and a digit.
interface seg_seconds_ctrl_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/seg_seconds_ctrl_seg7_decode.sv
// Purely combinational digit-to-segment decoder; digits above 9 blank the display.
module seg7_decode
    import seg_seconds_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    logic [6:0] term [NUM_DIGITS];

    // One match term per legal digit; at most one is non-zero, so OR-ing them decodes.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_term
            assign term[gi] = (digit == 4'(gi)) ? SEG_LUT[gi] : 7'h00;
        end
    endgenerate

    always_comb begin
        seg = 7'h00;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            seg = seg | term[i];
        end
    end

endmodule

// File: rtl/seg_seconds_ctrl.sv
// Seconds display controller: prescaler to a one-second tick, 0-9 digit counter,
// and a host command FSM (START/STOP/LOAD/CLEAR) with a one-cycle BUSY apply state.
module seg_seconds_ctrl
    import seg_seconds_pkg::*;
#(
    parameter int CLK_DIV = 10_000_000,
    parameter int DIV_W   = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    seg_seconds_ctrl_if.slave   cmd,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [3:0]          digit,
    output logic                tick,
    output logic                running,
    output logic                err
);

    localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(CLK_DIV - 1);

    state_e           state_reg, state_next;
    state_e           ret_state_reg, ret_state_next;
    logic [DIV_W-1:0] prescaler_reg, prescaler_next;
    logic [3:0]       digit_reg, digit_next;
    logic             dp_reg, dp_next;
    logic             tick_reg, tick_next;
    logic             err_reg, err_next;

    logic             ready_int;
    logic             accept;
    logic             wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= STOPPED;
            ret_state_reg <= STOPPED;
            prescaler_reg <= '0;
            digit_reg     <= 4'd0;
            dp_reg        <= 1'b0;
            tick_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ret_state_reg <= ret_state_next;
            prescaler_reg <= prescaler_next;
            digit_reg     <= digit_next;
            dp_reg        <= dp_next;
            tick_reg      <= tick_next;
            err_reg       <= err_next;
        end
    end

    // ready is also masked by rst so the host sees no acceptance window while in reset
    assign ready_int     = ena && (state_reg != BUSY);
    assign cmd.cmd_ready = ready_int && !rst;
    assign accept        = cmd.cmd_valid && ready_int;
    assign wrap          = ena && (state_reg == RUN) && (prescaler_reg == PRESC_MAX);

    always_comb begin
        state_next     = state_reg;
        ret_state_next = ret_state_reg;
        prescaler_next = prescaler_reg;
        digit_next     = digit_reg;
        dp_next        = dp_reg;
        tick_next      = 1'b0;
        err_next       = err_reg;

        if (ena) begin
            if (state_reg == RUN) begin
                if (wrap) begin
                    prescaler_next = '0;
                    tick_next      = 1'b1;
                    digit_next     = next_digit(digit_reg);
                    if (digit_reg == LAST_DIGIT) begin
                        dp_next = ~dp_reg;
                    end
                end else begin
                    prescaler_next = prescaler_reg + 1'b1;
                end
            end

            if (state_reg == BUSY) begin
                state_next = ret_state_reg;
            end

            // Command effects override a coinciding wrap, except START which leaves it alone.
            if (accept) begin
                state_next     = BUSY;
                ret_state_next = state_reg;
                case (cmd_op_e'(cmd.cmd_op))
                    OP_START: begin
                        ret_state_next = RUN;
                    end
                    OP_STOP: begin
                        ret_state_next = STOPPED;
                        digit_next     = digit_reg;
                        dp_next        = dp_reg;
                        tick_next      = 1'b0;
                    end
                    OP_LOAD: begin
                        digit_next = digit_reg;
                        dp_next    = dp_reg;
                        tick_next  = 1'b0;
                        if (digit_in_range(cmd.cmd_data)) begin
                            digit_next     = cmd.cmd_data;
                            prescaler_next = '0;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                    OP_CLEAR: begin
                        digit_next     = 4'd0;
                        prescaler_next = '0;
                        dp_next        = 1'b0;
                        err_next       = 1'b0;
                        tick_next      = 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    seg7_decode u_seg7_decode (
        .digit (digit_reg),
        .seg   (seg)
    );

    assign dp      = dp_reg;
    assign digit   = digit_reg;
    assign tick    = tick_reg;
    assign running = (state_reg == RUN);
    assign err     = err_reg;

endmodule

// File: tb/tb_seg_seconds_ctrl.sv
// Directed bench for seg_seconds_ctrl with a 4-cycle second so every path is reachable quickly.
module tb_seg_seconds_ctrl;
    import seg_seconds_pkg::*;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] digit;
    logic       tick;
    logic       running;
    logic       err;

    int n_vec;
    int n_bad;

    seg_seconds_ctrl_if cmd_if ();

    seg_seconds_ctrl #(
        .CLK_DIV (4),
        .DIV_W   (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .cmd     (cmd_if.slave),
        .seg     (seg),
        .dp      (dp),
        .digit   (digit),
        .tick    (tick),
        .running (running),
        .err     (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hand-written segment patterns for digits 0-9.
    logic [6:0] exp_seg [10];
    initial begin
        exp_seg[0] = 7'h3F; exp_seg[1] = 7'h06; exp_seg[2] = 7'h5B; exp_seg[3] = 7'h4F;
        exp_seg[4] = 7'h66; exp_seg[5] = 7'h6D; exp_seg[6] = 7'h7D; exp_seg[7] = 7'h07;
        exp_seg[8] = 7'h7F; exp_seg[9] = 7'h6F;
    end

    task automatic check(input string tag, input int got, input int want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present a command at a negedge and return at the negedge after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [3:0] data);
        logic r;
        r = 1'b0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = data;
        for (int k = 0; k < 50; k++) begin
            r = cmd_if.cmd_ready;
            @(negedge clk);
            if (r) break;
        end
        check("accept", int'(r), 1);
        cmd_if.cmd_valid = 1'b0;
    endtask

    // Number of negedges until tick is seen, or -1 if the bound expires.
    task automatic wait_tick(input int maxc, output int cyc);
        cyc = -1;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            if (tick) begin
                cyc = c;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int nt;
        logic [3:0] exp_d;
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        ena = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'b00;
        cmd_if.cmd_data  = 4'd0;

        // Reset values
        step(2);
        check("rst_seg", int'(seg), 'h3F);
        check("rst_digit", int'(digit), 0);
        check("rst_dp", int'(dp), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_running", int'(running), 0);
        check("rst_err", int'(err), 0);
        check("rst_ready", int'(cmd_if.cmd_ready), 0);
        rst = 1'b0;
        step(2);
        check("idle_ready", int'(cmd_if.cmd_ready), 1);
        check("idle_digit", int'(digit), 0);

        // START: one BUSY cycle, then RUN; a tick every 4 cycles
        send(OP_START, 4'd0);
        check("start_busy_ready", int'(cmd_if.cmd_ready), 0);
        check("start_busy_running", int'(running), 0);
        step(1);
        check("start_running", int'(running), 1);
        check("start_ready", int'(cmd_if.cmd_ready), 1);
        exp_d = 4'd0;
        for (int i = 1; i <= 10; i++) begin
            wait_tick(10, cyc);
            exp_d = (i == 10) ? 4'd0 : 4'(i);
            check($sformatf("tick%0d_period", i), cyc, 4);
            check($sformatf("tick%0d_digit", i), int'(digit), int'(exp_d));
            check($sformatf("tick%0d_seg", i), int'(seg), int'(exp_seg[exp_d]));
        end
        check("wrap_dp_set", int'(dp), 1);
        for (int i = 1; i <= 10; i++) begin
            wait_tick(10, cyc);
            check($sformatf("lap2_tick%0d_period", i), cyc, 4);
        end
        check("lap2_digit", int'(digit), 0);
        check("lap2_dp_clear", int'(dp), 0);

        // LOAD 7 restarts the prescaler: tick 4 cycles after the BUSY cycle
        send(OP_LOAD, 4'd7);
        check("load7_digit", int'(digit), 7);
        check("load7_seg", int'(seg), 'h07);
        wait_tick(12, cyc);
        check("load7_next_tick", cyc, 5);
        check("load7_then_digit", int'(digit), 8);
        send(OP_LOAD, 4'd12);
        check("load12_err", int'(err), 1);
        check("load12_digit", int'(digit), 8);
        send(OP_CLEAR, 4'd0);
        check("clear_err", int'(err), 0);
        check("clear_digit", int'(digit), 0);
        check("clear_seg", int'(seg), 'h3F);
        step(1);
        check("clear_running", int'(running), 1);
        wait_tick(10, cyc);
        check("clear_tick_period", cyc, 4);
        check("clear_tick_digit", int'(digit), 1);

        // STOP accepted on the wrap edge suppresses the tick and increment
        step(3);
        send(OP_STOP, 4'd0);
        check("stop_tick", int'(tick), 0);
        check("stop_digit", int'(digit), 1);
        step(1);
        check("stop_running", int'(running), 0);
        nt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (tick) nt++;
        end
        check("stopped_ticks", nt, 0);
        check("stopped_digit", int'(digit), 1);

        // ena low mid-RUN freezes everything and blocks a held command
        send(OP_START, 4'd0);
        wait_tick(12, cyc);
        check("restart_tick_seen", int'(cyc > 0), 1);
        check("restart_digit", int'(digit), 2);
        step(2);
        ena = 1'b0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_START;
        cmd_if.cmd_data  = 4'd0;
        #1;
        check("ena0_ready", int'(cmd_if.cmd_ready), 0);
        nt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (tick) nt++;
        end
        check("ena0_ticks", nt, 0);
        check("ena0_digit", int'(digit), 2);
        check("ena0_running", int'(running), 1);
        ena = 1'b1;
        #1;
        check("ena1_ready", int'(cmd_if.cmd_ready), 1);
        step(1);
        check("ena1_accepted_busy", int'(cmd_if.cmd_ready), 0);
        cmd_if.cmd_valid = 1'b0;
        wait_tick(10, cyc);
        check("ena1_tick_after", cyc, 2);
        check("ena1_digit", int'(digit), 3);

        // Asynchronous reset during BUSY drops the pending return to RUN
        send(OP_LOAD, 4'd4);
        check("busy_load_digit", int'(digit), 4);
        #2;
        rst = 1'b1;
        #1;
        check("async_digit", int'(digit), 0);
        check("async_seg", int'(seg), 'h3F);
        check("async_running", int'(running), 0);
        check("async_ready", int'(cmd_if.cmd_ready), 0);
        check("async_err", int'(err), 0);
        check("async_dp", int'(dp), 0);
        @(negedge clk);
        rst = 1'b0;
        step(2);
        check("post_rst_running", int'(running), 0);
        check("post_rst_digit", int'(digit), 0);
        check("post_rst_ready", int'(cmd_if.cmd_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_seconds_ctrl.md
Name: seg_seconds_ctrl

Overview:
Controller that sequences the seven-segment seconds display.
- Divides clk down to a one-second tick.
- Keeps a 0–9 digit counter and decodes it to segment drive.
- Accepts host commands over a valid/ready handshake: start, stop, load digit, clear.
- Sits between the top-level ui_in/uo_out pin mapping and the segment output.

Parameters:
CLK_DIV, 10_000_000, clk cycles per second tick (must be ≥2)
DIV_W, 24, prescaler width; must satisfy 2**DIV_W ≥ CLK_DIV

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
ena  in  1  design enable; low freezes all state
cmd_valid  in  1  command presented
cmd_ready  out  1  controller can accept command
cmd_op  in  2  00 START, 01 STOP, 10 LOAD, 11 CLEAR
cmd_data  in  4  digit value for LOAD; ignored otherwise
seg  out  7  segments gfedcba, active-high
dp  out  1  decimal point; toggles on each 9→0 wrap
digit  out  4  current digit, binary
tick  out  1  one-cycle pulse per second tick
running  out  1  state==RUN
err  out  1  sticky: LOAD with cmd_data>9

Behaviour:
Clock and reset:
- One clock, clk.
- rst is asynchronous and active-high.

Reset values:
- state=STOPPED, prescaler=0, digit=0, seg=7'h3F.
- dp=0, tick=0, running=0, err=0, cmd_ready=0.

States:
- STOPPED: prescaler held; display static.
- RUN: prescaler counts.
- BUSY: one-cycle command-apply state; cmd_ready=0.

Handshake:
- cmd_ready=1 in STOPPED/RUN when ena=1.
- A command is accepted on a clk edge with cmd_valid & cmd_ready.
- The next state is always BUSY for one cycle, then:
  - START → RUN
  - STOP → STOPPED
  - LOAD/CLEAR → return to the pre-command state
- Command effects (digit/err/prescaler/dp) are registered on the accept edge, so they are visible the cycle after accept.
- cmd_valid held while cmd_ready=0 is not consumed. The host holds cmd_op/cmd_data stable until accepted.

Prescaler:
- In RUN with ena=1, counts 0..CLK_DIV-1, then wraps to 0.
- On the wrap edge, tick=1 for exactly one cycle (registered) and digit increments.
- 9→0 wrap toggles dp.
- In BUSY the prescaler holds.

LOAD:
- cmd_data ≤ 9: digit=cmd_data, prescaler=0.
- cmd_data > 9: digit unchanged, err=1.

CLEAR:
- digit=0, prescaler=0, dp=0, err=0.

START in RUN and STOP in STOPPED are no-ops, but still pass through BUSY.

Simultaneous events:
- Command accept on the same edge as a prescaler wrap:
  - LOAD/CLEAR value wins; no increment, tick suppressed.
  - STOP: increment and tick suppressed.
  - START while running: wrap proceeds normally.

Enable:
- ena=0: all registers hold, tick=0, cmd_ready=0.

Segment decode:
- Combinational from registered digit, so seg changes the same cycle as digit.
- Patterns 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.

Reset mid-operation:
- Immediate return to reset values, including during BUSY.
- A pending command is dropped.

Decomposition:
- Package seg_seconds_pkg:
  - cmd_op encodings (OP_START/OP_STOP/OP_LOAD/OP_CLEAR)
  - state enum (STOPPED/RUN/BUSY)
  - SEG_LUT constant array of the 10 patterns
- One sub-module, seg7_decode: purely combinational digit→seg; out-of-range digit → 7'h00.

Test Plan:
- CLK_DIV=4; rst pulse, then START accepted → cmd_ready low 1 cycle, running=1; tick every 4 cycles; digit 0,1,2…; seg=06 when digit=1.
- Run to 9 then next tick → digit=0, seg=3F, dp toggles 0→1; a further 10 ticks → dp back to 0.
- LOAD 7 while RUN → digit=7 next cycle, prescaler restarts (next tick 4 cycles after BUSY); LOAD 12 → digit unchanged, err=1; CLEAR → err=0, digit=0.
- STOP issued on the cycle prescaler=3 → no tick, digit unchanged, running=0; hold 20 cycles → no ticks.
- ena=0 for 10 cycles mid-RUN → digit/prescaler frozen, cmd_ready=0, held cmd_valid accepted only once ena returns.
- Assert rst asynchronously between clk edges during BUSY → all outputs reset immediately; after release, state=STOPPED, digit=0, no command applied.
